serial_hsub: RTL and testbench

Bit-serial subtractor that computes `a - b` for two WIDTH-bit operands, one bit per clock, LSB first. The datapath is two chained half-subtractor cells plus a borrow flop. Operands are accepted and results delivered over valid/ready handshakes. It is the inverse-operation companion to the team's half-adder cell and sits behind the same Tiny Tapeout user I/O wrapper.

---
 rtl/serial_hsub_pkg.sv | 12 +
 rtl/serial_hsub_cell.sv | 10 +
 rtl/serial_hsub.sv | 102 ++++++++++
 tb/tb_serial_hsub.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/serial_hsub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_hsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } hsub_state_t;

  localparam int HSUB_WIDTH_DEF = 8;

endpackage

// File: rtl/serial_hsub_cell.sv
// Combinational half subtractor: d = x - y, bo = borrow out.
module hsub_cell (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);
  assign d  = x ^ y;
  assign bo = ~x & y;
endmodule

// File: rtl/serial_hsub.sv
// Bit-serial a - b, LSB first, one bit per clock, valid/ready on both sides.
module serial_hsub
  import serial_hsub_pkg::*;
#(
  parameter int WIDTH = HSUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);

  hsub_state_t      state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] diff_sr;
  logic [WIDTH-1:0] diff_cat;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt;
  logic             br, borrow_q;
  logic             t, bo1, d, bo2, br_nxt, last;

  hsub_cell u_cell1 (.x(a_sr[0]), .y(b_sr[0]), .d(t), .bo(bo1));
  hsub_cell u_cell2 (.x(t),       .y(br),      .d(d), .bo(bo2));

  assign br_nxt = bo1 | bo2;
  assign last   = (cnt == CW'(WIDTH - 1));
  // Only WIDTH-1 partial bits are stored; the final bit joins them on the last edge.
  assign diff_cat = {d, diff_sr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      diff_sr  <= '0;
      diff_q   <= '0;
      cnt      <= '0;
      br       <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sr <= a;
          b_sr <= b;
          br   <= 1'b0;
          cnt  <= '0;
        end
        RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          diff_sr <= diff_cat[WIDTH-1:1];
          br      <= br_nxt;
          if (!last) cnt <= cnt + 1'b1;
          else begin
            diff_q   <= diff_cat;
            borrow_q <= br_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_hsub.sv
// Directed table plus corner sequences and random ops for serial_hsub at WIDTH 8 and 16.
module tb_serial_hsub;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv = 1'b0;
  logic        ordy = 1'b1;
  logic [15:0] a_in = '0, b_in = '0;
  int          w_sel = 8;

  logic        ir8, ov8, br8, busy8, ir16, ov16, br16, busy16;
  logic [7:0]  diff8;
  logic [15:0] diff16;
  logic        iv8, iv16;

  assign iv8  = iv & (w_sel == 8);
  assign iv16 = iv & (w_sel == 16);

  always #5 clk = ~clk;

  serial_hsub #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a_in[7:0]), .b(b_in[7:0]),
    .out_valid(ov8), .out_ready(ordy), .diff(diff8), .borrow(br8), .busy(busy8));

  serial_hsub #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a_in), .b(b_in),
    .out_valid(ov16), .out_ready(ordy), .diff(diff16), .borrow(br16), .busy(busy16));

  logic        c_ov, c_ir, c_busy, c_br;
  logic [15:0] c_diff;
  assign c_ov   = (w_sel == 8) ? ov8   : ov16;
  assign c_ir   = (w_sel == 8) ? ir8   : ir16;
  assign c_busy = (w_sel == 8) ? busy8 : busy16;
  assign c_br   = (w_sel == 8) ? br8   : br16;
  assign c_diff = (w_sel == 8) ? {8'h00, diff8} : diff16;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One full operation: accept, wait for result, optional stall, handshake.
  task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input int stall,
                       input logic [15:0] ed, input logic eb, input string name);
    int lat;
    logic [15:0] held;
    @(negedge clk);
    chk({name, ".in_ready"}, 32'(c_ir), 1);
    a_in = av; b_in = bv; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    chk({name, ".busy"}, 32'(c_busy), 1);
    lat = 0;
    while (lat < 64) begin
      @(posedge clk); #1;
      lat++;
      if (c_ov) break;
    end
    chk({name, ".latency"}, 32'(lat), 32'(w_sel));
    chk({name, ".diff"}, 32'(c_diff), 32'(ed));
    chk({name, ".borrow"}, 32'(c_br), 32'(eb));
    held = c_diff;
    ordy = (stall == 0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk({name, ".hold_valid"}, 32'(c_ov), 1);
      chk({name, ".hold_diff"}, 32'(c_diff), 32'(held));
      if (s == stall - 1) ordy = 1'b1;
    end
    @(posedge clk); #1;
    chk({name, ".released"}, 32'(c_ov), 0);
    chk({name, ".ready_again"}, 32'(c_ir), 1);
    chk({name, ".diff_kept"}, 32'(c_diff), 32'(ed));
  endtask

  typedef struct {
    int          w;
    logic [15:0] a, b;
    int          stall;
    logic [15:0] ed;
    logic        eb;
    string       name;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{8,  16'd200,   16'd55,    0, 16'd145,   1'b0, "basic"};
    vecs[1]  = '{8,  16'd3,     16'd5,     0, 16'd254,   1'b1, "under_3_5"};
    vecs[2]  = '{8,  16'd0,     16'd0,     0, 16'd0,     1'b0, "zero_zero"};
    vecs[3]  = '{8,  16'd255,   16'd255,   0, 16'd0,     1'b0, "max_max"};
    vecs[4]  = '{8,  16'd0,     16'd1,     0, 16'd255,   1'b1, "under_0_1"};
    vecs[5]  = '{8,  16'd100,   16'd1,     5, 16'd99,    1'b0, "backpressure"};
    vecs[6]  = '{8,  16'd128,   16'd127,   2, 16'd1,     1'b0, "mid_8"};
    vecs[7]  = '{16, 16'd1000,  16'd2000,  0, 16'd64536, 1'b1, "w16_under"};
    vecs[8]  = '{16, 16'd65535, 16'd0,     1, 16'd65535, 1'b0, "w16_max"};
    vecs[9]  = '{16, 16'd0,     16'd65535, 0, 16'd1,     1'b1, "w16_zero_max"};
    vecs[10] = '{16, 16'd40000, 16'd1234,  3, 16'd38766, 1'b0, "w16_plain"};

    #1;
    chk("rst.in_ready8", 32'(ir8), 1);
    chk("rst.out_valid8", 32'(ov8), 0);
    chk("rst.busy8", 32'(busy8), 0);
    chk("rst.diff8", 32'(diff8), 0);
    chk("rst.borrow8", 32'(br8), 0);
    chk("rst.out_valid16", 32'(ov16), 0);
    chk("rst.diff16", 32'(diff16), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      w_sel = vecs[i].w;
      do_op(vecs[i].a, vecs[i].b, vecs[i].stall, vecs[i].ed, vecs[i].eb, vecs[i].name);
    end

    // in_valid pulsed during RUN must be ignored and yield no extra result
    begin
      int lat;
      int seen;
      w_sel = 8;
      @(negedge clk);
      a_in = 16'd50; b_in = 16'd20; iv = 1'b1;
      @(posedge clk); #1;
      iv = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      a_in = 16'd7; b_in = 16'd7; iv = 1'b1;
      @(posedge clk); #1;
      iv = 1'b0;
      lat = 4;
      while (lat < 64) begin
        @(posedge clk); #1;
        lat++;
        if (ov8) break;
      end
      chk("ignore.latency", 32'(lat), 8);
      chk("ignore.diff", 32'(diff8), 30);
      chk("ignore.borrow", 32'(br8), 0);
      @(posedge clk); #1;
      seen = 0;
      repeat (14) begin
        @(posedge clk); #1;
        if (ov8 || busy8) seen++;
      end
      chk("ignore.no_second", 32'(seen), 0);
    end

    // asynchronous reset in the middle of RUN
    w_sel = 8;
    @(negedge clk);
    a_in = 16'd123; b_in = 16'd45; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst.out_valid", 32'(ov8), 0);
    chk("midrst.busy", 32'(busy8), 0);
    chk("midrst.in_ready", 32'(ir8), 1);
    @(negedge clk);
    rst = 1'b0;
    do_op(16'd9, 16'd4, 0, 16'd5, 1'b0, "after_rst");

    // random operands and stalls against a plain unsigned subtract
    for (int n = 0; n < 2000; n++) begin
      logic [15:0] ra, rb, mask;
      w_sel = (n < 1000) ? 8 : 16;
      mask  = (w_sel == 8) ? 16'h00ff : 16'hffff;
      ra = 16'($urandom) & mask;
      rb = 16'($urandom) & mask;
      do_op(ra, rb, $urandom_range(0, 3), (ra - rb) & mask, ra < rb, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
